// File: rtl/arbitro_dados_ram_pkg.sv
// Shared definitions for the dados_RAM arbiter: requester ids, default geometry
// and the pending-read record carried from grant cycle to data cycle.
package arbitro_dados_ram_pkg;

  localparam int DATA_WIDTH_DEF   = 32;
  localparam int ADDR_WIDTH_DEF   = 32;
  localparam int PROFUNDIDADE_DEF = 2048;

  // Requester ids double as bit positions in the 2-bit req/gnt vectors.
  localparam logic DONO_PROC = 1'b0;
  localparam logic DONO_IO   = 1'b1;

  typedef struct packed {
    logic valid;
    logic dono;
    logic fora;
  } pend_t;

endpackage

// File: rtl/arbitro_dados_ram_rr2.sv
// Two-way round-robin arbiter: zero-wait combinational grant, pointer moves to
// the loser after every grant and holds while idle.
module arbitro_rr2
  import arbitro_dados_ram_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] i_req,
  output logic [1:0] o_gnt
);

  logic r_prio;

  always_comb begin
    o_gnt = 2'b00;
    if (!rst) begin
      case (i_req)
        2'b01:   o_gnt = 2'b01;
        2'b10:   o_gnt = 2'b10;
        2'b11:   o_gnt = (r_prio == DONO_IO) ? 2'b10 : 2'b01;
        default: o_gnt = 2'b00;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_prio <= DONO_PROC;
    end else if (o_gnt != 2'b00) begin
      r_prio <= o_gnt[DONO_PROC] ? DONO_IO : DONO_PROC;
    end
  end

endmodule

// File: rtl/arbitro_dados_ram.sv
// Arbitrates the single-ported data RAM between the processor and I/O paths;
// out-of-range accesses are consumed but never written, and flagged a cycle later.
module arbitro_dados_ram
  import arbitro_dados_ram_pkg::*;
#(
  parameter int DATA_WIDTH   = DATA_WIDTH_DEF,
  parameter int ADDR_WIDTH   = ADDR_WIDTH_DEF,
  parameter int PROFUNDIDADE = PROFUNDIDADE_DEF
) (
  input  logic                  clock,
  input  logic                  reset,

  input  logic                  proc_req,
  input  logic                  proc_we,
  input  logic [ADDR_WIDTH-1:0] proc_endereco,
  input  logic [DATA_WIDTH-1:0] proc_dado,
  output logic                  proc_gnt,
  output logic                  proc_rvalid,
  output logic [DATA_WIDTH-1:0] proc_q,

  input  logic                  io_req,
  input  logic                  io_we,
  input  logic [ADDR_WIDTH-1:0] io_endereco,
  input  logic [DATA_WIDTH-1:0] io_dado,
  output logic                  io_gnt,
  output logic                  io_rvalid,
  output logic [DATA_WIDTH-1:0] io_q,

  output logic [DATA_WIDTH-1:0] ram_data,
  output logic [ADDR_WIDTH-1:0] ram_endereco_leitura,
  output logic [ADDR_WIDTH-1:0] ram_endereco_escrita,
  output logic                  ram_we,
  input  logic [DATA_WIDTH-1:0] ram_q,

  output logic                  erro_endereco
);

  // One extra bit so PROFUNDIDADE == 2**ADDR_WIDTH still compares correctly.
  localparam logic [ADDR_WIDTH:0] LIMITE = (ADDR_WIDTH+1)'(PROFUNDIDADE);

  logic [1:0]            w_gnt;
  logic                  w_win;
  logic                  w_win_io;
  logic                  w_we_req;
  logic                  w_fora;
  logic [ADDR_WIDTH-1:0] w_addr;
  logic [DATA_WIDTH-1:0] w_data;

  pend_t r_pend_p1;
  logic  r_erro_p1;

  arbitro_rr2 u_rr2 (
    .clk   (clock),
    .rst   (reset),
    .i_req ({io_req, proc_req}),
    .o_gnt (w_gnt)
  );

  assign proc_gnt = w_gnt[DONO_PROC];
  assign io_gnt   = w_gnt[DONO_IO];
  assign w_win    = |w_gnt;
  assign w_win_io = w_gnt[DONO_IO];

  // stage p0: winner mux and range check, straight onto the RAM pins
  always_comb begin
    w_addr   = '0;
    w_data   = '0;
    w_we_req = 1'b0;
    if (w_win) begin
      w_addr   = w_win_io ? io_endereco : proc_endereco;
      w_data   = w_win_io ? io_dado     : proc_dado;
      w_we_req = w_win_io ? io_we       : proc_we;
    end
  end

  assign w_fora = w_win && ({1'b0, w_addr} >= LIMITE);

  assign ram_endereco_leitura = w_addr;
  assign ram_endereco_escrita = w_addr;
  assign ram_data             = w_data;
  assign ram_we               = w_win && w_we_req && !w_fora;

  // stage p1: remember who owns the read coming back from the RAM
  always_ff @(posedge clock) begin
    if (reset) begin
      r_pend_p1 <= '0;
      r_erro_p1 <= 1'b0;
    end else begin
      r_pend_p1.valid <= w_win && !w_we_req;
      r_pend_p1.dono  <= w_win_io;
      r_pend_p1.fora  <= w_fora;
      r_erro_p1       <= w_fora;
    end
  end

  assign erro_endereco = r_erro_p1;

  always_comb begin
    proc_rvalid = 1'b0;
    io_rvalid   = 1'b0;
    proc_q      = '0;
    io_q        = '0;
    if (!reset && r_pend_p1.valid) begin
      if (r_pend_p1.dono == DONO_IO) begin
        io_rvalid = 1'b1;
        io_q      = r_pend_p1.fora ? '0 : ram_q;
      end else begin
        proc_rvalid = 1'b1;
        proc_q      = r_pend_p1.fora ? '0 : ram_q;
      end
    end
  end

endmodule

// File: tb/tb_arbitro_dados_ram.sv
// Directed bench for arbitro_dados_ram: per-cycle vector table plus reset sequences,
// with a behavioural 1-cycle-latency dados_RAM attached.
module tb_arbitro_dados_ram;

  logic        clk = 1'b0;
  logic        reset;
  logic        proc_req, proc_we, io_req, io_we;
  logic [31:0] proc_endereco, proc_dado, io_endereco, io_dado;
  logic        proc_gnt, proc_rvalid, io_gnt, io_rvalid;
  logic [31:0] proc_q, io_q;
  logic [31:0] ram_data, ram_endereco_leitura, ram_endereco_escrita, ram_q;
  logic        ram_we, erro_endereco;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  arbitro_dados_ram #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .PROFUNDIDADE(2048)) dut (
    .clock(clk), .reset(reset),
    .proc_req(proc_req), .proc_we(proc_we), .proc_endereco(proc_endereco),
    .proc_dado(proc_dado), .proc_gnt(proc_gnt), .proc_rvalid(proc_rvalid), .proc_q(proc_q),
    .io_req(io_req), .io_we(io_we), .io_endereco(io_endereco),
    .io_dado(io_dado), .io_gnt(io_gnt), .io_rvalid(io_rvalid), .io_q(io_q),
    .ram_data(ram_data), .ram_endereco_leitura(ram_endereco_leitura),
    .ram_endereco_escrita(ram_endereco_escrita), .ram_we(ram_we), .ram_q(ram_q),
    .erro_endereco(erro_endereco)
  );

  // dados_RAM model: registered read, write on the same clock
  logic [31:0] mem [0:2047];
  always_ff @(posedge clk) begin
    if (ram_we) mem[ram_endereco_escrita[10:0]] <= ram_data;
    ram_q <= mem[ram_endereco_leitura[10:0]];
  end

  typedef struct {
    logic        pr, pw; logic [31:0] pa, pd;
    logic        ir, iw; logic [31:0] ia, id;
    logic        gp, gi, we; logic [31:0] ea, ed;
    logic        rvp; logic [31:0] qp;
    logic        rvi; logic [31:0] qi;
    logic        err;
  } vec_t;

  vec_t vt[$];

  task automatic chk(input string name, input int cyc, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  task automatic drive(input logic pr, pw, input logic [31:0] pa, pd,
                       input logic ir, iw, input logic [31:0] ia, id);
    proc_req = pr; proc_we = pw; proc_endereco = pa; proc_dado = pd;
    io_req = ir; io_we = iw; io_endereco = ia; io_dado = id;
  endtask

  task automatic check_vec(input vec_t v, input int c);
    chk("proc_gnt", c, 32'(proc_gnt), 32'(v.gp));
    chk("io_gnt", c, 32'(io_gnt), 32'(v.gi));
    chk("ram_we", c, 32'(ram_we), 32'(v.we));
    chk("ram_end_leit", c, ram_endereco_leitura, v.ea);
    chk("ram_end_escr", c, ram_endereco_escrita, v.ea);
    chk("ram_data", c, ram_data, v.ed);
    chk("proc_rvalid", c, 32'(proc_rvalid), 32'(v.rvp));
    chk("proc_q", c, proc_q, v.qp);
    chk("io_rvalid", c, 32'(io_rvalid), 32'(v.rvi));
    chk("io_q", c, io_q, v.qi);
    chk("erro_endereco", c, 32'(erro_endereco), 32'(v.err));
  endtask

  initial begin
    // pr pw pa pd | ir iw ia id | gp gi we ea ed | rvp qp | rvi qi | err
    vt.push_back('{1,1,5,32'hDEADBEEF, 0,0,0,0, 1,0,1,5,32'hDEADBEEF, 0,0, 0,0, 0}); // 0
    vt.push_back('{1,0,5,0, 0,0,0,0, 1,0,0,5,0, 0,0, 0,0, 0});                       // 1
    vt.push_back('{0,0,0,0, 0,0,0,0, 0,0,0,0,0, 1,32'hDEADBEEF, 0,0, 0});            // 2
    vt.push_back('{1,1,1,32'h11, 0,0,0,0, 1,0,1,1,32'h11, 0,0, 0,0, 0});             // 3
    vt.push_back('{0,0,0,0, 1,1,2,32'h22, 0,1,1,2,32'h22, 0,0, 0,0, 0});             // 4
    vt.push_back('{1,0,1,0, 1,0,2,0, 1,0,0,1,0, 0,0, 0,0, 0});                       // 5
    vt.push_back('{1,0,1,0, 1,0,2,0, 0,1,0,2,0, 1,32'h11, 0,0, 0});                  // 6
    vt.push_back('{1,0,1,0, 1,0,2,0, 1,0,0,1,0, 0,0, 1,32'h22, 0});                  // 7
    vt.push_back('{1,0,1,0, 1,0,2,0, 0,1,0,2,0, 1,32'h11, 0,0, 0});                  // 8
    vt.push_back('{0,0,0,0, 0,0,0,0, 0,0,0,0,0, 0,0, 1,32'h22, 0});                  // 9
    vt.push_back('{0,0,0,0, 1,1,7,32'hA5, 0,1,1,7,32'hA5, 0,0, 0,0, 0});             // 10
    vt.push_back('{1,0,7,0, 0,0,0,0, 1,0,0,7,0, 0,0, 0,0, 0});                       // 11
    vt.push_back('{0,0,0,0, 0,0,0,0, 0,0,0,0,0, 1,32'hA5, 0,0, 0});                  // 12
    vt.push_back('{0,0,0,0, 0,0,0,0, 0,0,0,0,0, 0,0, 0,0, 0});                       // 13
    vt.push_back('{1,0,1,0, 1,0,2,0, 0,1,0,2,0, 0,0, 0,0, 0});                       // 14 prio held io
    vt.push_back('{1,0,1,0, 1,0,2,0, 1,0,0,1,0, 0,0, 1,32'h22, 0});                  // 15
    vt.push_back('{0,0,0,0, 0,0,0,0, 0,0,0,0,0, 1,32'h11, 0,0, 0});                  // 16
    vt.push_back('{1,1,32'h800,32'h1234, 0,0,0,0, 1,0,0,32'h800,32'h1234, 0,0, 0,0, 0}); // 17
    vt.push_back('{1,1,32'h7FF,32'h7FF00001, 0,0,0,0, 1,0,1,32'h7FF,32'h7FF00001, 0,0, 0,0, 1}); // 18
    vt.push_back('{1,0,32'h7FF,0, 0,0,0,0, 1,0,0,32'h7FF,0, 0,0, 0,0, 0});           // 19
    vt.push_back('{0,0,0,0, 1,0,32'h1000,0, 0,1,0,32'h1000,0, 1,32'h7FF00001, 0,0, 0}); // 20
    vt.push_back('{0,0,0,0, 0,0,0,0, 0,0,0,0,0, 0,0, 1,0, 1});                       // 21

    // reset held two cycles with a pending request: nothing may be granted
    reset = 1'b1;
    drive(1, 1, 5, 32'h0BAD0BAD, 1, 0, 3, 0);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk); #1;
      chk("rst_proc_gnt", i, 32'(proc_gnt), 0);
      chk("rst_io_gnt", i, 32'(io_gnt), 0);
      chk("rst_ram_we", i, 32'(ram_we), 0);
      chk("rst_proc_rvalid", i, 32'(proc_rvalid), 0);
      chk("rst_io_q", i, io_q, 0);
    end
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < vt.size(); i++) begin
      drive(vt[i].pr, vt[i].pw, vt[i].pa, vt[i].pd, vt[i].ir, vt[i].iw, vt[i].ia, vt[i].id);
      #1;
      check_vec(vt[i], i);
      @(negedge clk);
    end

    // proc read granted, moving priority to io
    drive(1, 0, 1, 0, 0, 0, 0, 0);
    #1;
    chk("seq_a_proc_gnt", 100, 32'(proc_gnt), 1);
    @(negedge clk);
    // reset while that read is in flight and another proc read is asking
    reset = 1'b1;
    drive(1, 0, 5, 0, 0, 0, 0, 0);
    #1;
    chk("seq_b_proc_gnt", 101, 32'(proc_gnt), 0);
    chk("seq_b_proc_rvalid", 101, 32'(proc_rvalid), 0);
    chk("seq_b_proc_q", 101, proc_q, 0);
    chk("seq_b_ram_we", 101, 32'(ram_we), 0);
    @(negedge clk);
    // after reset priority is back to proc; the read during reset is dropped
    reset = 1'b0;
    drive(1, 0, 1, 0, 1, 0, 2, 0);
    #1;
    chk("seq_c_proc_rvalid", 102, 32'(proc_rvalid), 0);
    chk("seq_c_proc_gnt", 102, 32'(proc_gnt), 1);
    chk("seq_c_io_gnt", 102, 32'(io_gnt), 0);
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    chk("seq_d_proc_rvalid", 103, 32'(proc_rvalid), 1);
    chk("seq_d_proc_q", 103, proc_q, 32'h11);
    chk("seq_d_io_rvalid", 103, 32'(io_rvalid), 0);
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/arbitro_dados_ram.md
Name: arbitro_dados_ram

Overview:
Arbitrates single-ported access to the data RAM (dados_RAM) between two requesters: the processor load/store path ("proc") and the I/O/DMA path ("io").
- Both RAM clocks (read_clock, write_clock) are tied to this block's clock.
- At most one RAM operation is issued per cycle.
- Grants are round-robin and zero-wait. Read data is returned one cycle after the grant, to the requester that issued the read.
- Out-of-range addresses are trapped and never reach the RAM.

Parameters:
DATA_WIDTH, 32, data word width (matches dados_RAM)
ADDR_WIDTH, 32, address width (matches dados_RAM)
PROFUNDIDADE, 2048, number of RAM words; valid addresses are 0..PROFUNDIDADE-1

Ports:
clock  input  1  single system clock; also drives RAM read_clock and write_clock
reset  input  1  synchronous, active-high reset
proc_req  input  1  processor requests an access; held until granted
proc_we  input  1  1 = write, 0 = read
proc_endereco  input  ADDR_WIDTH  word address
proc_dado  input  DATA_WIDTH  write data
proc_gnt  output  1  request accepted at the coming posedge
proc_rvalid  output  1  proc_q holds read data this cycle
proc_q  output  DATA_WIDTH  read data
io_req, io_we, io_endereco, io_dado, io_gnt, io_rvalid, io_q  same widths and meanings, I/O requester
ram_data  output  DATA_WIDTH  to RAM data
ram_endereco_leitura  output  ADDR_WIDTH  to RAM read address
ram_endereco_escrita  output  ADDR_WIDTH  to RAM write address
ram_we  output  1  to RAM we
ram_q  input  DATA_WIDTH  from RAM q (registered inside the RAM, 1-cycle latency)
erro_endereco  output  1  one-cycle pulse: a granted access was out of range

Behaviour:
- Reset (synchronous, active-high), including mid-operation:
  - prioridade <= proc.
  - Pending-read register cleared (valid=0).
  - erro_endereco <= 0.
  - While reset is high: all gnt = 0, ram_we = 0, both rvalid = 0, both q = 0.
  - A read granted in the cycle reset is asserted is dropped (no rvalid afterwards).
- Handshake: a requester holds req, we, endereco and dado stable until it samples gnt=1 at a posedge. gnt is combinational from req and prioridade, with no wait state.
- Arbitration, per cycle:
  - Only one req high: that requester is granted.
  - Both high: the requester named by prioridade is granted, then prioridade <= the other requester.
  - A single-requester grant also sets prioridade to the other requester.
  - Neither high: no grant, ram_we=0, prioridade holds.
- RAM drive (combinational from the winner):
  - ram_endereco_leitura = ram_endereco_escrita = winner endereco.
  - ram_data = winner dado.
  - ram_we = winner we AND in-range.
  - With no winner, addresses and data hold 0.
- Write: grant in cycle N; the RAM is written at the end-of-N posedge. There is no response beyond gnt.
- Read, granted in cycle N:
  - Pending register <= {valid=1, dono=winner, fora=out-of-range}.
  - In cycle N+1 the owner's rvalid=1 and its q = (fora ? 0 : ram_q). The other requester's rvalid=0 and q=0.
- Back-to-back grants every cycle are allowed, including alternating reads between requesters. The pending register is overwritten each cycle, so throughput is 1 op/cycle.
- Write-then-read to the same address in consecutive cycles returns the new data. The same-cycle read/write hazard cannot occur (one op per cycle).
- Out of range (endereco >= PROFUNDIDADE):
  - The request is still granted and consumed; ram_we is forced to 0.
  - erro_endereco=1 in cycle N+1 for both reads and writes.
  - A read returns rvalid with q=0.
- rvalid and q are zero whenever not valid. There is no backpressure on read data: the requester must accept it in that cycle.

Decomposition:
- Shared package:
  - DONO_PROC=1'b0 and DONO_IO=1'b1 constants.
  - Default PROFUNDIDADE/DATA_WIDTH/ADDR_WIDTH constants, shared with dados_RAM instantiation.
  - Pending-read struct {valid, dono, fora}.
- Optional sub-module: arbitro_rr2 (2-way round-robin grant plus pointer update), reusable for other shared resources. Everything else stays in this module.

Test Plan:
1. Reset for 2 cycles, then proc write addr 5 = 0xDEADBEEF, then proc read addr 5 -> proc_gnt in the same cycle as each req; proc_rvalid=1 with proc_q=0xDEADBEEF exactly one cycle after the read grant; io_rvalid=0 throughout.
2. proc and io both request reads (addr 1 = 0x11, addr 2 = 0x22 preloaded) continuously for 4 cycles -> grants alternate proc, io, proc, io; rvalid alternates one cycle later with 0x11/0x22; 1 op/cycle.
3. io writes addr 7 = 0xA5 in cycle N, proc reads addr 7 in N+1 -> proc_q=0xA5 in N+2.
4. proc write addr 2048 = 0x1234 -> gnt=1, ram_we=0, erro_endereco pulse in the next cycle; a subsequent read of addr 2047 is unaffected; io read of addr 4096 -> io_rvalid=1, io_q=0, erro pulse.
5. Reset asserted in the cycle a proc read is granted -> no proc_rvalid the next cycle, prioridade=proc after reset (a simultaneous proc+io request is granted to proc first).
6. Idle cycles (no req) -> ram_we=0, no gnt, no rvalid, prioridade unchanged across the idle gap.
